// File: rtl/bsg_pll_scan_cfg_ctrl.sv
// Scan-chain configuration sequencer for the on-chip PLLs: one PLL at a time, MSB-first shift, readback returned.
// Define BSG_PLL_CFG_VERIFY_EN to add a second identical shift pass that verifies the chain contents.
module bsg_pll_scan_cfg_ctrl #(
  parameter int num_pll_p     = 2,
  parameter int width_p       = 32,
  parameter int clk_div_p     = 4,
  parameter int lock_cycles_p = 1024,
  localparam int sel_w_lp     = (num_pll_p > 1) ? $clog2(num_pll_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 cfg_v_i,
  input  logic [sel_w_lp-1:0]  cfg_sel_i,
  input  logic [width_p-1:0]   cfg_data_i,
  output logic                 cfg_ready_o,
  output logic                 done_v_o,
  output logic [width_p-1:0]   done_data_o,
  output logic                 done_err_o,
  input  logic                 done_yumi_i,
  output logic                 scn_clk_o,
  output logic [num_pll_p-1:0] pll_cs_o,
  output logic [num_pll_p-1:0] pll_sdi_o,
  output logic [num_pll_p-1:0] pll_rstb_o,
  input  logic [num_pll_p-1:0] pll_sdo_i
);
  localparam int hp_w_lp   = $clog2(clk_div_p + 1);
  localparam int bit_w_lp  = $clog2(width_p + 1);
  localparam int lock_w_lp = $clog2(lock_cycles_p + 1);
  localparam logic [hp_w_lp-1:0]   hp_load_lp   = hp_w_lp'(clk_div_p);
  localparam logic [bit_w_lp-1:0]  bit_load_lp  = bit_w_lp'(width_p);
  localparam logic [lock_w_lp-1:0] lock_load_lp = lock_w_lp'(lock_cycles_p);

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, SHIFT, CS_HOLD, LOCK, DONE
`ifdef BSG_PLL_CFG_VERIFY_EN
    , CS_SETUP2, SHIFT2, CS_HOLD2
`endif
  } state_e;

  state_e state_r, state_n;

  logic                 live_r;
  logic [sel_w_lp-1:0]  sel_r;
  logic [width_p-1:0]   sh_r, rb_r, done_data_r;
  logic [hp_w_lp-1:0]   hp_cnt_r;
  logic [bit_w_lp-1:0]  bit_cnt_r;
  logic [lock_w_lp-1:0] lock_cnt_r;
  logic                 scn_clk_r, err_r;
  logic [num_pll_p-1:0] cs_r, sdi_r, rstb_r;
`ifdef BSG_PLL_CFG_VERIFY_EN
  logic [width_p-1:0]   data_r;
`endif

  logic accept, sel_ok, hp_last, bit_last, lock_last;
  logic is_setup, is_shift, is_hold, finish;

  assign cfg_ready_o = live_r & (state_r == IDLE);
  assign done_v_o    = (state_r == DONE);
  assign done_data_o = done_data_r;
  assign done_err_o  = err_r;
  assign scn_clk_o   = scn_clk_r;
  assign pll_cs_o    = cs_r;
  assign pll_sdi_o   = sdi_r;
  assign pll_rstb_o  = rstb_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    accept    = cfg_v_i & cfg_ready_o;
    sel_ok    = 32'(cfg_sel_i) < 32'(num_pll_p);
    hp_last   = (hp_cnt_r == hp_w_lp'(1));
    bit_last  = (bit_cnt_r == bit_w_lp'(1));
    lock_last = (lock_cnt_r == lock_w_lp'(1));
    is_setup  = (state_r == CS_SETUP);
    is_shift  = (state_r == SHIFT);
    is_hold   = (state_r == CS_HOLD);
`ifdef BSG_PLL_CFG_VERIFY_EN
    is_setup  = is_setup | (state_r == CS_SETUP2);
    is_shift  = is_shift | (state_r == SHIFT2);
    is_hold   = is_hold  | (state_r == CS_HOLD2);
`endif
    state_n = state_r;
    unique case (state_r)
      IDLE:     if (accept) state_n = sel_ok ? CS_SETUP : DONE;
      CS_SETUP: if (hp_last) state_n = SHIFT;
      SHIFT:    if (hp_last && scn_clk_r && bit_last) state_n = CS_HOLD;
`ifdef BSG_PLL_CFG_VERIFY_EN
      CS_HOLD:   if (hp_last) state_n = CS_SETUP2;
      CS_SETUP2: if (hp_last) state_n = SHIFT2;
      SHIFT2:    if (hp_last && scn_clk_r && bit_last) state_n = CS_HOLD2;
      CS_HOLD2:  if (hp_last) state_n = LOCK;
`else
      CS_HOLD:  if (hp_last) state_n = LOCK;
`endif
      LOCK:     if (lock_last) state_n = DONE;
      DONE:     if (done_yumi_i) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    finish = is_hold & hp_last & (state_n == LOCK);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      live_r      <= 1'b0;
      sel_r       <= '0;
      sh_r        <= '0;
      rb_r        <= '0;
      done_data_r <= '0;
      hp_cnt_r    <= '0;
      bit_cnt_r   <= '0;
      lock_cnt_r  <= '0;
      scn_clk_r   <= 1'b0;
      err_r       <= 1'b0;
      cs_r        <= '0;
      sdi_r       <= '0;
      rstb_r      <= '0;
`ifdef BSG_PLL_CFG_VERIFY_EN
      data_r      <= '0;
`endif
    end else begin
      live_r <= 1'b1;
      if (state_r == IDLE && accept) begin
        sel_r    <= cfg_sel_i;
        sh_r     <= cfg_data_i;
        hp_cnt_r <= hp_load_lp;
`ifdef BSG_PLL_CFG_VERIFY_EN
        data_r   <= cfg_data_i;
`endif
        if (sel_ok) begin
          cs_r[cfg_sel_i]   <= 1'b1;
          rstb_r[cfg_sel_i] <= 1'b0;
        end else begin
          err_r       <= 1'b1;
          done_data_r <= '0;
        end
      end
      // first data bit goes out together with entry into the low phase
      if (is_setup) begin
        if (!hp_last) hp_cnt_r <= hp_cnt_r - 1'b1;
        else begin
          hp_cnt_r     <= hp_load_lp;
          bit_cnt_r    <= bit_load_lp;
          sdi_r[sel_r] <= sh_r[width_p-1];
          sh_r         <= {sh_r[width_p-2:0], 1'b0};
        end
      end
      if (is_shift) begin
        if (!hp_last) hp_cnt_r <= hp_cnt_r - 1'b1;
        else begin
          hp_cnt_r <= hp_load_lp;
          if (!scn_clk_r) scn_clk_r <= 1'b1;
          else begin
            scn_clk_r <= 1'b0;
            rb_r      <= {rb_r[width_p-2:0], pll_sdo_i[sel_r]};
            if (!bit_last) begin
              bit_cnt_r    <= bit_cnt_r - 1'b1;
              sdi_r[sel_r] <= sh_r[width_p-1];
              sh_r         <= {sh_r[width_p-2:0], 1'b0};
            end
          end
        end
      end
      if (is_hold) begin
        if (!hp_last) hp_cnt_r <= hp_cnt_r - 1'b1;
        else if (finish) begin
          cs_r[sel_r]   <= 1'b0;
          sdi_r[sel_r]  <= 1'b0;
          rstb_r[sel_r] <= 1'b1;
          lock_cnt_r    <= lock_load_lp;
          done_data_r   <= rb_r;
`ifdef BSG_PLL_CFG_VERIFY_EN
          err_r         <= (rb_r != data_r);
`else
          err_r         <= 1'b0;
`endif
        end
`ifdef BSG_PLL_CFG_VERIFY_EN
        else begin
          hp_cnt_r <= hp_load_lp;
          sh_r     <= data_r;
        end
`endif
      end
      if (state_r == LOCK && !lock_last) lock_cnt_r <= lock_cnt_r - 1'b1;
    end
  end
endmodule

// File: tb/tb_bsg_pll_scan_cfg_ctrl.sv
// Directed bench for bsg_pll_scan_cfg_ctrl with a behavioural scan-chain model per PLL (3 PLLs so an invalid sel is encodable).
module tb_bsg_pll_scan_cfg_ctrl;
  localparam int N = 3, W = 8, D = 2, L = 16;
`ifdef BSG_PLL_CFG_VERIFY_EN
  localparam int  EXP_LAT = 1 + 2*(D + 2*D*W + D) + L;
  localparam int  EXP_RISE = 2*W;
  localparam bit  VER = 1'b1;
`else
  localparam int  EXP_LAT = 1 + D + 2*D*W + D + L;
  localparam int  EXP_RISE = W;
  localparam bit  VER = 1'b0;
`endif

  logic clk = 0, reset_n = 0, cfg_v = 0, yumi = 0;
  logic [1:0]   cfg_sel = '0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_ready, done_v, done_err, scn_clk;
  logic [W-1:0] done_data;
  logic [N-1:0] pll_cs, pll_sdi, pll_rstb, pll_sdo;

  logic [W-1:0] chain [N];
  logic [N-1:0] cap;
  logic         stuck = 0;
  logic [1:0]   mon_sel = '0;
  logic [W-1:0] sdi_log = '0;
  int           rise_cnt = 0;
  int           errors = 0, checks = 0;

  bsg_pll_scan_cfg_ctrl #(.num_pll_p(N), .width_p(W), .clk_div_p(D), .lock_cycles_p(L)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cfg_v_i(cfg_v), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
    .cfg_ready_o(cfg_ready), .done_v_o(done_v), .done_data_o(done_data), .done_err_o(done_err),
    .done_yumi_i(yumi), .scn_clk_o(scn_clk), .pll_cs_o(pll_cs), .pll_sdi_o(pll_sdi),
    .pll_rstb_o(pll_rstb), .pll_sdo_i(pll_sdo));

  always #5 clk = ~clk;

  // chain captures sdi on rising scan clock and advances on falling, so sdo holds each bit through the high phase
  always @(posedge scn_clk) begin
    for (int i = 0; i < N; i++) if (pll_cs[i]) cap[i] = pll_sdi[i];
    rise_cnt = rise_cnt + 1;
    sdi_log  = {sdi_log[W-2:0], pll_sdi[mon_sel]};
  end
  always @(negedge scn_clk)
    for (int i = 0; i < N; i++) if (pll_cs[i]) chain[i] = {chain[i][W-2:0], cap[i]};
  always_comb
    for (int i = 0; i < N; i++) pll_sdo[i] = stuck ? 1'b0 : chain[i][W-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // called at posedge+1 with cfg_ready high; returns cycles from accept edge to done_v
  task automatic send(input logic [1:0] s, input logic [W-1:0] d, output int lat, output logic bad);
    logic [N-1:0] one, other, rb0;
    one = 1; other = ~(one << s); rb0 = pll_rstb;
    mon_sel = s; rise_cnt = 0; bad = 0;
    cfg_v = 1; cfg_sel = s; cfg_data = d;
    @(posedge clk); #1 cfg_v = 0; lat = 1;
    while (!done_v && lat < 500) begin
      if (((pll_cs | pll_sdi | (pll_rstb ^ rb0)) & other) != '0) bad = 1;
      @(posedge clk); #1 lat++;
    end
  endtask

  task automatic consume();
    yumi = 1; @(posedge clk); #1 yumi = 0;
  endtask

  initial begin
    int lat; logic bad, held_bad; logic [W-1:0] snap;
    chain[0] = 8'h3C; chain[1] = 8'h12; chain[2] = 8'h81; cap = '0;

    repeat (3) @(posedge clk); #1;
    chk("rst_ready", cfg_ready, 0);
    chk("rst_outs", {done_v, done_err, scn_clk, pll_cs, pll_sdi, pll_rstb}, 0);
    chk("rst_data", done_data, 0);
    reset_n = 1; @(posedge clk); #1;
    chk("idle_ready", cfg_ready, 1);
    chk("idle_outs", {done_v, done_err, scn_clk, pll_cs, pll_sdi, pll_rstb}, 0);

    send(2'd0, 8'hA5, lat, bad);
    chk("a_latency", lat, EXP_LAT);
    chk("a_sdi_bits", sdi_log, 8'hA5);
    chk("a_rises", rise_cnt, EXP_RISE);
    chk("a_data", done_data, VER ? 8'hA5 : 8'h3C);
    chk("a_err", done_err, 0);
    chk("a_rstb", pll_rstb, 3'b001);
    chk("a_others_static", bad, 0);
    chk("a_busy_ready", cfg_ready, 0);
    consume();
    chk("a_yumi_done", done_v, 0);
    chk("a_yumi_ready", cfg_ready, 1);

    send(2'd1, 8'hFF, lat, bad);
    chk("b_done", done_v, 1);
    snap = done_data; held_bad = 0;
    for (int k = 0; k < 10; k++) begin
      cfg_v = 1; cfg_sel = 2'd0; cfg_data = 8'h00;
      @(posedge clk); #1;
      if (!done_v || done_data !== snap || cfg_ready || pll_cs !== '0) held_bad = 1;
    end
    cfg_v = 0;
    chk("b_held_stable", held_bad, 0);
    chk("b_data", done_data, VER ? 8'hFF : 8'h12);
    chk("b_rstb", pll_rstb, 3'b011);
    consume();
    chk("b_ignored_cfg", {done_v, cfg_ready, pll_cs}, {1'b0, 1'b1, 3'b000});

    yumi = 1; @(posedge clk); #1 yumi = 0;
    chk("stray_yumi", {done_v, cfg_ready}, 2'b01);

    send(2'd2, 8'h5A, lat, bad);
    chk("c_data", done_data, VER ? 8'h5A : 8'h81);
    chk("c_err", done_err, 0);
    chk("c_rstb", pll_rstb, 3'b111);
    consume();

    stuck = 1;
    send(2'd2, 8'h5A, lat, bad);
    chk("d_data", done_data, 8'h00);
    chk("d_err", done_err, VER ? 1 : 0);
    consume();
    stuck = 0;

    send(2'd3, 8'hC3, lat, bad);
    chk("e_latency", lat, 1);
    chk("e_err", done_err, 1);
    chk("e_data", done_data, 0);
    chk("e_rises", rise_cnt, 0);
    chk("e_no_pins", bad, 0);
    consume();

    cfg_v = 1; cfg_sel = 2'd0; cfg_data = 8'h0F;
    @(posedge clk); #1 cfg_v = 0;
    repeat (10) @(posedge clk); #1;
    chk("f_shifting_cs", pll_cs, 3'b001);
    reset_n = 0; @(posedge clk); #1;
    chk("f_rst_outs", {done_v, done_err, scn_clk, pll_cs, pll_sdi, pll_rstb, cfg_ready}, 0);
    chk("f_rst_data", done_data, 0);
    reset_n = 1; @(posedge clk); #1;
    chk("f_ready_back", {cfg_ready, done_v}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
